// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle MIPS stage sequencer: PC, one-hot stage enables, watchdog, retire count
// Optional: define STAGE_SEQ_MEM_SKIP_EN to send non-memory instructions from EXEC straight to WB.
module stage_sequencer #(
    parameter int PC_W     = 4,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [4:0]       stage_done,
    input  logic             end_program,
    input  logic             branch,
    input  logic             zero,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             stage1,
    output logic             stage2,
    output logic             stage3,
    output logic             stage4,
    output logic             stage5,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

`ifdef STAGE_SEQ_MEM_SKIP_EN
    localparam bit MEM_SKIP = 1'b1;
`else
    localparam bit MEM_SKIP = 1'b0;
`endif

    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       stage_q, stage_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  br_target_q, br_target_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             br_taken_q, br_taken_d;
    logic             is_mem_q, is_mem_d;
    logic             halted_q, halted_d;
    logic             timeout_err_q, timeout_err_d;
    logic             done_cur;
    logic             wd_expired;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        br_target_d   = br_target_q;
        retired_d     = retired_q;
        br_taken_d    = br_taken_q;
        is_mem_d      = is_mem_q;
        timeout_err_d = timeout_err_q;
        // Only the done bit of the currently enabled stage can advance the sequence.
        done_cur      = |(stage_done & stage_q);
        wd_expired    = (TIMEOUT > 0) && (wd_q == WD_LAST);

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (done_cur) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (done_cur) begin
                    if (end_program) begin
                        state_d = S_HALT;
                    end else begin
                        is_mem_d = mem_read | mem_write;
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (done_cur) begin
                    br_taken_d  = branch & zero;
                    br_target_d = branch_target;
                    state_d     = (MEM_SKIP && !is_mem_q) ? S_WB : S_MEM;
                end
            end
            S_MEM: begin
                if (done_cur) state_d = S_WB;
            end
            S_WB: begin
                if (done_cur) begin
                    pc_d       = br_taken_q ? br_target_q : pc_q + 1'b1;
                    retired_d  = (retired_q == '1) ? retired_q : retired_q + 1'b1;
                    br_taken_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_HALT: begin
                if (run) begin
                    timeout_err_d = 1'b0;
                    pc_d          = PC_INIT;
                    retired_d     = '0;
                    br_taken_d    = 1'b0;
                    is_mem_d      = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A done on the expiry edge still advances; abort only when the stage stalled.
        if ((|stage_q) && !done_cur && wd_expired) begin
            state_d       = S_HALT;
            timeout_err_d = 1'b1;
        end

        case (state_d)
            S_FETCH:  stage_d = 5'b00001;
            S_DECODE: stage_d = 5'b00010;
            S_EXEC:   stage_d = 5'b00100;
            S_MEM:    stage_d = 5'b01000;
            S_WB:     stage_d = 5'b10000;
            default:  stage_d = 5'b00000;
        endcase

        halted_d = (state_d == S_HALT);
        wd_d     = ((state_d != state_q) || !(|stage_q)) ? '0 : wd_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            stage_q       <= '0;
            pc_q          <= PC_INIT;
            br_target_q   <= '0;
            retired_q     <= '0;
            wd_q          <= '0;
            br_taken_q    <= 1'b0;
            is_mem_q      <= 1'b0;
            halted_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            pc_q          <= pc_d;
            br_target_q   <= br_target_d;
            retired_q     <= retired_d;
            wd_q          <= wd_d;
            br_taken_q    <= br_taken_d;
            is_mem_q      <= is_mem_d;
            halted_q      <= halted_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign stage1      = stage_q[0];
    assign stage2      = stage_q[1];
    assign stage3      = stage_q[2];
    assign stage4      = stage_q[3];
    assign stage5      = stage_q[4];
    assign busy        = |stage_q;
    assign halted      = halted_q;
    assign timeout_err = timeout_err_q;
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - randomized self-checking bench for stage_sequencer
module tb_stage_sequencer;
    localparam int PC_W    = 4;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             run;
    logic [4:0]       stage_done;
    logic             end_program;
    logic             branch;
    logic             zero;
    logic [PC_W-1:0]  branch_target;
    logic             mem_read;
    logic             mem_write;
    logic             stage1, stage2, stage3, stage4, stage5;
    logic [PC_W-1:0]  pc;
    logic             busy;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] retired;

    stage_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (0),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .run           (run),
        .stage_done    (stage_done),
        .end_program   (end_program),
        .branch        (branch),
        .zero          (zero),
        .branch_target (branch_target),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .stage1        (stage1),
        .stage2        (stage2),
        .stage3        (stage3),
        .stage4        (stage4),
        .stage5        (stage5),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .timeout_err   (timeout_err),
        .retired       (retired)
    );

    always #5 clock = ~clock;

    wire [4:0] stg = {stage5, stage4, stage3, stage2, stage1};

    int checks   = 0;
    int failures = 0;
    int m_pc     = 0;
    int m_ret    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick_delay(input bit fast);
        return fast ? 1 : int'($urandom_range(1, 4));
    endfunction

    // Holds one stage for 'cycles' edges; the done bit (if given) is on the last one.
    task automatic do_stage(input int s, input int cycles, input bit give_done);
        logic [4:0] exp_stg;
        exp_stg = 5'b00001 << s;
        for (int c = 1; c <= cycles; c++) begin
            check_val($sformatf("stage_vec_s%0d", s + 1), stg, exp_stg);
            check_val("busy", busy, 1);
            stage_done = 5'($urandom) & ~exp_stg;
            if (give_done && c == cycles) stage_done = stage_done | exp_stg;
            run = 1'($urandom);
            @(posedge clock);
            #1;
        end
        stage_done = '0;
        run        = 1'b0;
    endtask

    task automatic check_halt(input bit exp_to);
        check_val("halt_stg", stg, 0);
        check_val("halt_busy", busy, 0);
        check_val("halt_flag", halted, 1);
        check_val("halt_timeout", timeout_err, exp_to);
        check_val("halt_pc", pc, m_pc);
        check_val("halt_retired", retired, m_ret);
    endtask

    task automatic start_run();
        run = 1'b1;
        @(posedge clock);
        #1;
        run   = 1'b0;
        m_pc  = 0;
        m_ret = 0;
        check_val("start_stage1", stg, 5'b00001);
        check_val("start_pc", pc, 0);
        check_val("start_retired", retired, 0);
        check_val("start_halted", halted, 0);
        check_val("start_timeout", timeout_err, 0);
    endtask

    task automatic do_instr(input bit endp, input bit br, input bit z, input int tgt,
                            input bit mr, input bit mw, input bit fast, input int exec_cycles);
        end_program   = endp;
        branch        = br;
        zero          = z;
        branch_target = PC_W'(tgt);
        mem_read      = mr;
        mem_write     = mw;
        do_stage(0, pick_delay(fast), 1'b1);
        do_stage(1, pick_delay(fast), 1'b1);
        if (endp) begin
            check_halt(1'b0);
            return;
        end
        do_stage(2, (exec_cycles > 0) ? exec_cycles : pick_delay(fast), 1'b1);
`ifdef STAGE_SEQ_MEM_SKIP_EN
        if (mr || mw) do_stage(3, pick_delay(fast), 1'b1);
`else
        do_stage(3, pick_delay(fast), 1'b1);
`endif
        do_stage(4, pick_delay(fast), 1'b1);
        m_pc  = (br && z) ? tgt : (m_pc + 1) % (1 << PC_W);
        m_ret = (m_ret < (1 << CNT_W) - 1) ? m_ret + 1 : m_ret;
        check_val("wb_pc", pc, m_pc);
        check_val("wb_retired", retired, m_ret);
        check_val("wb_next_fetch", stg, 5'b00001);
    endtask

    initial begin
        reset_n       = 1'b0;
        run           = 1'b0;
        stage_done    = '0;
        end_program   = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        branch_target = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("rst_stg", stg, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_timeout", timeout_err, 0);
        check_val("rst_pc", pc, 0);
        check_val("rst_retired", retired, 0);
        reset_n = 1'b1;

        // Done bits while IDLE must not start anything.
        for (int i = 0; i < 4; i++) begin
            stage_done = 5'($urandom);
            @(posedge clock);
            #1;
            check_val("idle_stays", stg, 0);
        end
        stage_done = '0;
        start_run();

        // Back-to-back minimum-latency instructions.
        for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 0, 0, 0, 1, 0);
        check_val("seq_pc3", pc, 3);

        do_instr(1, 0, 0, 0, 1, 1, 1, 0);
        start_run();

        // Branch taken/not-taken, tight loop, and PC wrap.
        do_instr(0, 1, 1, 5, 0, 0, 0, 0);
        do_instr(0, 1, 1, 9, 0, 0, 0, 0);
        check_val("br_taken_pc9", pc, 9);
        do_instr(0, 1, 1, 5, 0, 0, 0, 0);
        do_instr(0, 1, 0, 9, 0, 0, 0, 0);
        check_val("br_not_taken_pc6", pc, 6);
        do_instr(0, 1, 1, 6, 1, 0, 0, 0);
        do_instr(0, 1, 1, 15, 0, 1, 0, 0);
        do_instr(0, 0, 1, 3, 0, 0, 0, 0);
        check_val("pc_wrap", pc, 0);

        // Watchdog: EXEC stalls for TIMEOUT cycles.
        end_program = 1'b0;
        branch      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        do_stage(0, 1, 1'b1);
        do_stage(1, 2, 1'b1);
        do_stage(2, TIMEOUT, 1'b0);
        check_halt(1'b1);
        start_run();
        do_instr(0, 0, 0, 0, 1, 0, 0, TIMEOUT);
        check_val("late_done_no_err", timeout_err, 0);

        // Asynchronous reset while in MEM.
        mem_read = 1'b1;
        do_stage(0, 1, 1'b1);
        do_stage(1, 1, 1'b1);
        do_stage(2, 1, 1'b1);
        check_val("in_mem", stg, 5'b01000);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_stg", stg, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_pc", pc, 0);
        check_val("arst_retired", retired, 0);
        @(negedge clock);
        reset_n = 1'b1;
        m_pc    = 0;
        m_ret   = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            check_val("post_rst_idle", stg, 0);
        end
        start_run();

        // Long run without end_program so the retire counter saturates.
        for (int i = 0; i < 18; i++)
            do_instr(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                     1'($urandom), 1'($urandom), 0, 0);
        check_val("retired_sat", retired, (1 << CNT_W) - 1);

        for (int i = 0; i < 300; i++) begin
            bit endp;
            endp = ($urandom_range(0, 11) == 0);
            do_instr(endp, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                     1'($urandom), 1'($urandom), 1'($urandom), 0);
            if (endp) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock);
                    #1;
                end
                check_val("halt_hold", halted, 1);
                start_run();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
